// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_arbiter                                                   |
// | Description : Writeback arbiter between EXU and LSU in front of the RF     |
// |               write port, with a per-register pending scoreboard for       |
// |               decode hazard stalls. Optional perf counters are enabled     |
// |               with the WB_PERF_CNT_EN macro.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [AW-1:0]   exu_rd,
    input  logic            exu_wen,
    input  logic [XLEN-1:0] exu_data,

    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_data,

    output logic            rf_wen,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_data,

    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
`ifdef WB_PERF_CNT_EN
    output logic [31:0]     perf_exu_cnt,
    output logic [31:0]     perf_lsu_cnt,
    output logic [31:0]     perf_conf_cnt,
`endif
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    localparam logic c_SRC_EXU = 1'b0;
    localparam logic c_SRC_LSU = 1'b1;

    logic            r_last_grant;
    logic            r_rf_wen;
    logic [AW-1:0]   r_rf_addr;
    logic [XLEN-1:0] r_rf_data;

    logic            w_gnt_exu;
    logic            w_gnt_lsu;
    logic            w_acc;
    logic [AW-1:0]   w_sel_rd;
    logic            w_sel_wen;
    logic [XLEN-1:0] w_sel_data;
    logic            w_wr;
    logic            w_issue_set;
    logic [NREG-1:0] w_pend;

    // Round-robin: on a conflict the source that did not win last time goes
    always_comb begin
        w_gnt_exu  = exu_valid & (~lsu_valid | (r_last_grant == c_SRC_LSU));
        w_gnt_lsu  = lsu_valid & (~exu_valid | (r_last_grant == c_SRC_EXU));
        w_acc      = w_gnt_exu | w_gnt_lsu;
        w_sel_rd   = w_gnt_lsu ? lsu_rd   : exu_rd;
        w_sel_wen  = w_gnt_lsu ? lsu_wen  : exu_wen;
        w_sel_data = w_gnt_lsu ? lsu_data : exu_data;
        w_wr       = w_acc & w_sel_wen & (w_sel_rd != '0);
    end

    assign exu_ready = w_gnt_exu;
    assign lsu_ready = w_gnt_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_SRC_LSU;
        end else if (w_acc) begin
            r_last_grant <= w_gnt_lsu ? c_SRC_LSU : c_SRC_EXU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_wen  <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_wen <= w_wr;
            if (w_acc) begin
                r_rf_addr <= w_sel_rd;
                r_rf_data <= w_sel_data;
            end
        end
    end

    assign rf_wen  = r_rf_wen;
    assign rf_addr = r_rf_addr;
    assign rf_data = r_rf_data;

    // Scoreboard: x0 is hardwired clear, so it is never busy and always issuable
    assign issue_ready = ~w_pend[issue_rd];
    assign w_issue_set = issue_valid & issue_ready & (issue_rd != '0);

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_pend
            if (i == 0) begin : g_zero
                assign w_pend[i] = 1'b0;
            end else begin : g_bit
                logic r_bit;
                // Set has priority: a new writer issuing on the write edge keeps it pending
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_bit <= 1'b0;
                    end else if (w_issue_set && (issue_rd == AW'(i))) begin
                        r_bit <= 1'b1;
                    end else if (r_rf_wen && (r_rf_addr == AW'(i))) begin
                        r_bit <= 1'b0;
                    end
                end
                assign w_pend[i] = r_bit;
            end
        end
    endgenerate

    assign rs1_busy = w_pend[rs1_addr];
    assign rs2_busy = w_pend[rs2_addr];

`ifdef WB_PERF_CNT_EN
    logic [31:0] r_perf_exu;
    logic [31:0] r_perf_lsu;
    logic [31:0] r_perf_conf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_exu  <= '0;
            r_perf_lsu  <= '0;
            r_perf_conf <= '0;
        end else begin
            if (w_gnt_exu) begin
                r_perf_exu <= r_perf_exu + 32'd1;
            end
            if (w_gnt_lsu) begin
                r_perf_lsu <= r_perf_lsu + 32'd1;
            end
            if (exu_valid && lsu_valid) begin
                r_perf_conf <= r_perf_conf + 32'd1;
            end
        end
    end

    assign perf_exu_cnt  = r_perf_exu;
    assign perf_lsu_cnt  = r_perf_lsu;
    assign perf_conf_cnt = r_perf_conf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_arbiter                                                |
// | Description : Self-checking bench for wb_arbiter with directed cases and   |
// |               randomized traffic against a behavioural model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            exu_valid = 1'b0, exu_wen = 1'b0, lsu_valid = 1'b0, lsu_wen = 1'b0;
    logic            issue_valid = 1'b0;
    logic [AW-1:0]   exu_rd = '0, lsu_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
    logic [XLEN-1:0] exu_data = '0, lsu_data = '0;
    logic            exu_ready, lsu_ready, rf_wen, issue_ready, rs1_busy, rs2_busy;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_data;
`ifdef WB_PERF_CNT_EN
    logic [31:0]     perf_exu_cnt, perf_lsu_cnt, perf_conf_cnt;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
        .exu_wen(exu_wen), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_wen(lsu_wen), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
`ifdef WB_PERF_CNT_EN
        .perf_exu_cnt(perf_exu_cnt), .perf_lsu_cnt(perf_lsu_cnt),
        .perf_conf_cnt(perf_conf_cnt),
`endif
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who is owed the next conflict, the pending set, and
    // the write expected on the RF port in the current cycle.
    bit              m_lsu_went_last;
    bit              m_pend [NREG];
    bit              m_rf_wen;
    logic [AW-1:0]   m_rf_addr;
    logic [XLEN-1:0] m_rf_data;
    int              m_winner;
    int unsigned     m_exu_cnt, m_lsu_cnt, m_conf_cnt;

    task automatic model_reset();
        m_lsu_went_last = 1'b1;
        foreach (m_pend[r]) m_pend[r] = 1'b0;
        m_rf_wen  = 1'b0;
        m_rf_addr = '0;
        m_rf_data = '0;
        m_winner  = 0;
        m_exu_cnt = 0;
        m_lsu_cnt = 0;
        m_conf_cnt = 0;
    endtask

    // 0 = nobody, 1 = EXU, 2 = LSU
    function automatic int winner();
        if (exu_valid && lsu_valid) return m_lsu_went_last ? 1 : 2;
        if (exu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    task automatic compare();
        int w;
        w = winner();
        check("exu_ready", exu_ready, w == 1);
        check("lsu_ready", lsu_ready, w == 2);
        check("issue_ready", issue_ready, (issue_rd == 0) || !m_pend[issue_rd]);
        check("rs1_busy", rs1_busy, (rs1_addr != 0) && m_pend[rs1_addr]);
        check("rs2_busy", rs2_busy, (rs2_addr != 0) && m_pend[rs2_addr]);
        check("rf_wen", rf_wen, m_rf_wen);
        if (m_rf_wen) begin
            check("rf_addr", rf_addr, m_rf_addr);
            check("rf_data", rf_data, m_rf_data);
        end
`ifdef WB_PERF_CNT_EN
        check("perf_exu", perf_exu_cnt, m_exu_cnt);
        check("perf_lsu", perf_lsu_cnt, m_lsu_cnt);
        check("perf_conf", perf_conf_cnt, m_conf_cnt);
`endif
    endtask

    task automatic model_step();
        int w;
        bit legal_issue, new_wen;
        w = winner();
        legal_issue = issue_valid && (issue_rd != 0) && !m_pend[issue_rd];
        if (m_rf_wen) m_pend[m_rf_addr] = 1'b0;
        if (legal_issue) m_pend[issue_rd] = 1'b1;
        if (exu_valid && lsu_valid) m_conf_cnt++;
        new_wen = 1'b0;
        if (w == 1) begin
            new_wen = exu_wen && (exu_rd != 0);
            m_rf_addr = exu_rd;
            m_rf_data = exu_data;
            m_exu_cnt++;
            m_lsu_went_last = 1'b0;
        end else if (w == 2) begin
            new_wen = lsu_wen && (lsu_rd != 0);
            m_rf_addr = lsu_rd;
            m_rf_data = lsu_data;
            m_lsu_cnt++;
            m_lsu_went_last = 1'b1;
        end
        m_rf_wen = new_wen;
        m_winner = w;
    endtask

    // Entered just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        #1 compare();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic idle();
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_random();
        if (!exu_valid || m_winner == 1) begin
            exu_valid = ($urandom_range(0, 9) < 6);
            exu_rd    = AW'($urandom_range(0, 7));
            exu_wen   = ($urandom_range(0, 4) != 0);
            exu_data  = $urandom;
        end
        if (!lsu_valid || m_winner == 2) begin
            lsu_valid = ($urandom_range(0, 9) < 6);
            lsu_rd    = AW'($urandom_range(0, 7));
            lsu_wen   = ($urandom_range(0, 4) != 0);
            lsu_data  = $urandom;
        end
        issue_rd    = AW'($urandom_range(0, 7));
        issue_valid = ($urandom_range(0, 2) == 0);
        if (issue_valid && m_pend[issue_rd] && $urandom_range(0, 4) != 0) issue_valid = 1'b0;
        rs1_addr = AW'($urandom_range(0, 7));
        rs2_addr = AW'($urandom_range(0, 7));
    endtask

    initial begin
        int exp_addr [4];
        exp_addr = '{1, 2, 1, 2};
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_rf_wen", rf_wen, 1'b0);
        check("reset_rf_addr", rf_addr, 0);
        check("reset_rf_data", rf_data, 0);
        check("reset_exu_ready", exu_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single EXU write
        exu_valid = 1'b1; exu_rd = 5; exu_wen = 1'b1; exu_data = 32'hDEADBEEF;
        #1 check("t1_exu_ready", exu_ready, 1'b1);
        cycle();
        exu_valid = 1'b0;
        #1;
        check("t1_rf_wen", rf_wen, 1'b1);
        check("t1_rf_addr", rf_addr, 5);
        check("t1_rf_data", rf_data, 32'hDEADBEEF);
        cycle();
        check("t1_rf_wen_once", rf_wen, 1'b0);

        // Sustained conflict from reset: EXU, LSU, EXU, LSU
        do_reset();
        exu_valid = 1'b1; exu_rd = 1; exu_wen = 1'b1; exu_data = 32'h1111_0001;
        lsu_valid = 1'b1; lsu_rd = 2; lsu_wen = 1'b1; lsu_data = 32'h2222_0002;
        for (int k = 0; k < 4; k++) begin
            #1 check("t2_exu_grant", exu_ready, (k % 2) == 0);
            cycle();
            check("t2_rf_addr_seq", rf_addr, exp_addr[k]);
        end
        idle();
        cycle();

        // Scoreboard set by issue, cleared on the LSU write edge
        issue_valid = 1'b1; issue_rd = 7; rs1_addr = 7;
        cycle();
        issue_valid = 1'b0;
        #1;
        check("t3_busy_set", rs1_busy, 1'b1);
        check("t3_issue_blocked", issue_ready, 1'b0);
        cycle();
        lsu_valid = 1'b1; lsu_rd = 7; lsu_wen = 1'b1; lsu_data = 32'h0000_0777;
        cycle();
        lsu_valid = 1'b0;
        #1 check("t3_busy_before_edge", rs1_busy, 1'b1);
        cycle();
        check("t3_busy_cleared", rs1_busy, 1'b0);

        // Write and issue of rd=3 on the same edge: set wins
        exu_valid = 1'b1; exu_rd = 3; exu_wen = 1'b1; exu_data = 32'h3;
        cycle();
        exu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 3; rs2_addr = 3;
        cycle();
        issue_valid = 1'b0;
        #1 check("t4_set_wins", rs2_busy, 1'b1);
        cycle();

        // rd=0 and wen=0 are consumed without writing; x0 never pends
        exu_valid = 1'b1; exu_rd = 0; exu_wen = 1'b1;
        cycle();
        exu_rd = 9; exu_wen = 1'b0;
        check("t5_rd0_no_write", rf_wen, 1'b0);
        cycle();
        exu_valid = 1'b0;
        check("t5_wen0_no_write", rf_wen, 1'b0);
        issue_valid = 1'b1; issue_rd = 0; rs1_addr = 0;
        #1 check("t5_x0_ready", issue_ready, 1'b1);
        cycle();
        issue_valid = 1'b0;
        check("t5_x0_busy", rs1_busy, 1'b0);

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                exu_valid = 1'b1; exu_rd = 4; exu_wen = 1'b1;
                lsu_valid = 1'b1; lsu_rd = 6; lsu_wen = 1'b1;
                issue_valid = 1'b1; issue_rd = 5;
                rs1_addr = 5; rs2_addr = 6;
                cycle();
                issue_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check("rst_rf_wen", rf_wen, 1'b0);
                check("rst_rs1_busy", rs1_busy, 1'b0);
                check("rst_rs2_busy", rs2_busy, 1'b0);
`ifdef WB_PERF_CNT_EN
                check("rst_perf_exu", perf_exu_cnt, 0);
                check("rst_perf_lsu", perf_lsu_cnt, 0);
                check("rst_perf_conf", perf_conf_cnt, 0);
`endif
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("rst_first_exu", exu_ready, 1'b1);
                check("rst_first_lsu", lsu_ready, 1'b0);
                cycle();
            end
            drive_random();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
